// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, arbitrates the imem port between fetch and loader,
// and runs the BOOT/RUN/HALT sequence.
module fetch_controller #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              halt_req_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i,
    output logic              ld_ready_o,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_target_i,
    input  logic              stall_i,
    output logic [31:0]       pc_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [1:0]        state_o,
    output logic [31:0]       fetch_count_o,
    output logic              misalign_err_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        mis_q, mis_d;
    logic        fetch_valid, flush, ld_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        mis_d       = mis_q;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        ld_ready    = 1'b0;
        case (state_q)
            BOOT: begin
                ld_ready = ld_valid_i;
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                end
            end
            RUN: begin
                // Priority: halt > redirect > loader steal > stall > fetch.
                if (halt_req_i) begin
                    state_d = HALT;
                end else if (redirect_valid_i) begin
                    flush = 1'b1;
                    pc_d  = {redirect_target_i[31:2], 2'b00};
                    if (redirect_target_i[1:0] != 2'b00) mis_d = 1'b1;
                end else if (ld_valid_i) begin
                    ld_ready = 1'b1;
                end else if (!stall_i) begin
                    fetch_valid = 1'b1;
                    pc_d        = pc_q + 32'd4;
                    count_d     = count_q + 32'd1;
                end
            end
            HALT: begin
                ld_ready = ld_valid_i;
                if (start_i) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    assign ld_ready_o     = ld_ready & ~rst_i;
    assign mem_we_o       = ld_ready & ~rst_i;
    assign fetch_valid_o  = fetch_valid & ~rst_i;
    assign flush_o        = flush & ~rst_i;
    assign mem_waddr_o    = rst_i ? '0 : ld_addr_i;
    assign mem_wdata_o    = rst_i ? '0 : ld_data_i;
    assign pc_o           = pc_q;
    assign mem_raddr_o    = pc_q[ADDR_W+1:2];
    assign state_o        = state_q;
    assign fetch_count_o  = count_q;
    assign misalign_err_o = mis_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed test-plan sequence with literal checks, then random traffic,
// all cycles compared against a behavioural model.
module tb_fetch_controller;

    localparam int unsigned ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, halt_req = 1'b0, ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [31:0]       ld_data = '0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_target = '0;
    logic              stall = 1'b0;

    logic              ld_ready, fetch_valid, flush, mem_we, misalign_err;
    logic [31:0]       pc, mem_wdata, fetch_count;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    fetch_controller #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .halt_req_i(halt_req),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
        .redirect_valid_i(redirect_valid), .redirect_target_i(redirect_target), .stall_i(stall),
        .pc_o(pc), .fetch_valid_o(fetch_valid), .flush_o(flush), .mem_raddr_o(mem_raddr),
        .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .state_o(state),
        .fetch_count_o(fetch_count), .misalign_err_o(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state 0=BOOT 1=RUN 2=HALT; advanced once per cycle at negedge.
    int          m_state = 0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_cnt = 0;
    logic        m_mis = 0;

    always @(negedge clk) begin
        logic e_fv, e_fl, e_rdy;
        int          n_state;
        logic [31:0] n_pc, n_cnt;
        logic        n_mis;
        if (rst) begin
            m_state = 0; m_pc = RESET_PC; m_cnt = 0; m_mis = 0;
            chk("rst_state", 32'(state), 0);
            chk("rst_pc", pc, RESET_PC);
            chk("rst_count", fetch_count, 0);
            chk("rst_mis", 32'(misalign_err), 0);
            chk("rst_comb", {26'd0, fetch_valid, flush, ld_ready, mem_we, 2'b00}, 0);
            chk("rst_wport", {mem_waddr, mem_wdata[23:0]} | 32'(mem_wdata[31:24]), 0);
        end else begin
            e_fv = 0; e_fl = 0; e_rdy = 0;
            n_state = m_state; n_pc = m_pc; n_cnt = m_cnt; n_mis = m_mis;
            if (m_state != 1) begin
                e_rdy = ld_valid;
                if (start) begin
                    n_state = 1;
                    if (m_state == 0) n_pc = RESET_PC;
                end
            end else if (halt_req) begin
                n_state = 2;
            end else if (redirect_valid) begin
                e_fl = 1;
                n_pc = redirect_target - (redirect_target % 4);
                if (redirect_target % 4 != 0) n_mis = 1;
            end else if (ld_valid) begin
                e_rdy = 1;
            end else if (!stall) begin
                e_fv = 1; n_pc = m_pc + 4; n_cnt = m_cnt + 1;
            end
            chk("state", 32'(state), 32'(m_state));
            chk("pc", pc, m_pc);
            chk("count", fetch_count, m_cnt);
            chk("misalign", 32'(misalign_err), 32'(m_mis));
            chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
            chk("flush", 32'(flush), 32'(e_fl));
            chk("ld_ready", 32'(ld_ready), 32'(e_rdy));
            chk("mem_we", 32'(mem_we), 32'(e_rdy));
            chk("mem_raddr", 32'(mem_raddr), (m_pc / 4) % (1 << ADDR_W));
            if (e_rdy) begin
                chk("mem_waddr", 32'(mem_waddr), 32'(ld_addr));
                chk("mem_wdata", mem_wdata, ld_data);
            end
            m_state = n_state; m_pc = n_pc; m_cnt = n_cnt; m_mis = n_mis;
        end
    end

    task automatic drive(input logic st, input logic hr, input logic lv, input logic [ADDR_W-1:0] la,
                         input logic [31:0] ldd, input logic rv, input logic [31:0] rt, input logic sl);
        @(posedge clk);
        #1;
        start = st; halt_req = hr; ld_valid = lv; ld_addr = la; ld_data = ldd;
        redirect_valid = rv; redirect_target = rt; stall = sl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, 0, '0, 0);
    endtask

    logic [31:0] words [4] = '{32'h8E71_0014, 32'h8E28_0000, 32'h8D12_0000, 32'h0251_8020};

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("lit_rst_state", 32'(state), 0);
        @(posedge clk); #1 rst = 0;

        for (int unsigned i = 0; i < 4; i++) begin
            drive(0, 0, 1, ADDR_W'(i), words[i], 0, '0, 0);
            chk("lit_boot_we", 32'(mem_we), 1);
            chk("lit_boot_wdata", mem_wdata, words[i]);
        end
        drive(1, 0, 0, '0, '0, 0, '0, 0);
        chk("lit_boot_hold", 32'(state), 0);
        idle();
        chk("lit_run_pc0", pc, 32'h0);
        chk("lit_run_fv", 32'(fetch_valid), 1);
        idle();                                   // pc 4
        drive(0, 0, 0, '0, '0, 0, '0, 1);
        chk("lit_stall_pc", pc, 32'h8);
        chk("lit_stall_fv", 32'(fetch_valid), 0);
        drive(0, 0, 0, '0, '0, 0, '0, 1);
        chk("lit_stall_cnt", fetch_count, 2);
        idle();
        chk("lit_post_stall_fv", 32'(fetch_valid), 1);
        idle();
        chk("lit_post_stall_pc", pc, 32'hC);
        drive(0, 0, 0, '0, '0, 1, 32'h38, 1);
        chk("lit_pc10", pc, 32'h10);
        chk("lit_cnt4", fetch_count, 4);
        chk("lit_redir_flush", 32'(flush), 1);
        idle();
        chk("lit_redir_pc", pc, 32'h38);
        chk("lit_redir_fv", 32'(fetch_valid), 1);
        drive(0, 0, 0, '0, '0, 1, 32'h3A, 0);
        idle();
        chk("lit_mis_pc", pc, 32'h38);
        chk("lit_mis", 32'(misalign_err), 1);
        drive(0, 0, 0, '0, '0, 1, 32'h100, 0);
        idle();
        chk("lit_mis_sticky", 32'(misalign_err), 1);

        drive(0, 0, 1, 8'h20, 32'hDEAD_BEEF, 1, 32'h40, 0);
        chk("lit_steal_wait", 32'(ld_ready), 0);
        drive(0, 0, 1, 8'h20, 32'hDEAD_BEEF, 0, '0, 0);
        chk("lit_steal_pc", pc, 32'h40);
        chk("lit_steal_we", 32'(mem_we), 1);
        chk("lit_steal_waddr", 32'(mem_waddr), 32'h20);
        chk("lit_steal_fv", 32'(fetch_valid), 0);
        drive(0, 1, 0, '0, '0, 0, '0, 0);
        drive(0, 0, 1, 8'h05, 32'h1234_5678, 0, '0, 0);
        chk("lit_halt_state", 32'(state), 2);
        chk("lit_halt_pc", pc, 32'h40);
        chk("lit_halt_ld", 32'(ld_ready), 1);
        drive(1, 0, 0, '0, '0, 0, '0, 0);
        idle();
        chk("lit_resume_state", 32'(state), 1);
        chk("lit_resume_pc", pc, 32'h40);
        idle();
        chk("lit_resume_pc2", pc, 32'h44);

        drive(0, 0, 0, '0, '0, 1, 32'hFFFF_FFFC, 0);
        idle();
        chk("lit_wrap_raddr_hi", 32'(mem_raddr), 32'hFF);
        idle();
        chk("lit_wrap_pc", pc, 32'h0);
        chk("lit_wrap_raddr", 32'(mem_raddr), 32'h0);

        @(posedge clk); #1;
        ld_valid = 1; ld_addr = 8'h07; ld_data = 32'hCAFE_F00D;
        start = 0; halt_req = 0; redirect_valid = 0; stall = 0;
        #2 rst = 1;
        #1;
        chk("lit_arst_state", 32'(state), 0);
        chk("lit_arst_pc", pc, RESET_PC);
        chk("lit_arst_we", 32'(mem_we), 0);
        chk("lit_arst_cnt", fetch_count, 0);
        @(posedge clk); #1 rst = 0; ld_valid = 0;

        for (int unsigned c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst             = ($urandom % 400) == 0;
            start           = ($urandom % 8) == 0;
            halt_req        = ($urandom % 25) == 0;
            ld_valid        = ($urandom % 4) == 0;
            ld_addr         = ADDR_W'($urandom);
            ld_data         = $urandom;
            redirect_valid  = ($urandom % 6) == 0;
            redirect_target = (($urandom % 10) == 0) ? 32'hFFFF_FFF0 | 32'($urandom % 16) : $urandom;
            if (($urandom % 4) != 0) redirect_target[1:0] = 2'b00;
            stall           = ($urandom % 5) == 0;
        end
        @(posedge clk); #1 rst = 0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
